bcd_counter_display: RTL
========================

Name: bcd_counter_display

Overview:
Parametrised successor to the fixed 3-digit decimal counter/display block, for the same 7-segment board family.
- Counts in BCD over DIGITS digits, up or down, with load, clear, enable and wrap flag.
- Time-multiplexes the digits onto one shared segment bus with leading-zero blanking.
- Sits between the board clock and the common-anode/cathode 7-segment pins; the count is also exported for other logic.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz
TICK_HZ, 1, count rate in Hz; prescaler terminal = CLK_HZ/TICK_HZ - 1 (must be >= 1)
SCAN_DIV, 10000, clocks per displayed digit slot (>= 1)
DIGITS, 3, number of BCD digits / display positions (1..8)
ACTIVE_LOW, 1, 1 = seg and an outputs inverted (lit = 0); 0 = lit = 1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
en  in  1  count enable, sampled on tick
up  in  1  1 = increment, 0 = decrement
clear  in  1  synchronous clear of count to 0
load  in  1  synchronous load of load_val
load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0]
count_bcd  out  4*DIGITS  current count, digit 0 = least significant
wrap  out  1  one-cycle pulse when the count wraps
seg  out  8  segments: [6:0] = g..a, [7] = dp
an  out  DIGITS  digit enables, one-hot when lit

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - count_bcd = 0, wrap = 0, prescaler = 0, scan counter = 0, scan index = 0.
  - seg and an are all-off after the ACTIVE_LOW polarity is applied.
- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1; tick is a 1-cycle pulse at the terminal value, then the prescaler wraps to 0.
  - clear and load also zero the prescaler.
- Count priority per cycle: clear > load > (tick & en) > hold.
- Load: any load_val digit > 9 is clamped to 9.
- Up count:
  - Digit 0 increments; a 9 becomes 0 and carries into the next digit (ripple, same cycle).
  - All-9s becomes all-0s and asserts wrap for exactly that cycle.
- Down count:
  - A 0 becomes 9 and borrows from the next digit.
  - All-0s becomes all-9s and asserts wrap.
- wrap is registered and is 0 on every cycle except a wrapping tick.
- count_bcd updates on the clk edge that samples the event (latency 1).
- Active-digit count N: index of the highest non-zero digit + 1, minimum 1.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 continuously.
  - At its terminal value the scan index advances by 1, wrapping to 0 after N-1.
  - If N shrinks below index+1 (count change or clear), the index is forced to 0 on the next clk edge.
- Leading-zero blanking: digits at index >= N are never enabled.
- Output pipeline: digit mux, then registered segment decode and registered an.
  - seg and an change together, 1 cycle after the scan index changes.
  - Decode values (active-high, before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; non-BCD = 00.
- an is one-hot on the current index.

Optional Feature:
BCD_DISP_DP_EN:
- Defined: adds input dp_mask [DIGITS-1:0]. seg[7] is lit when dp_mask[index] = 1, registered with seg. A digit whose dp bit is set is always scanned, even above N (N = max of the blanking rule and the highest set dp bit + 1).
- Undefined: no dp_mask port; seg[7] is always off.

Decomposition:
- Package bcd_disp_pkg:
  - bcd_digit_t (4-bit) typedef.
  - The ten segment-code constants and SEG_BLANK.
  - Function for BCD increment/decrement of one digit with carry/borrow out.
- One sub-module: bcd_seg_decoder. Registered 4-bit to 8-bit decode with the polarity parameter; instantiated once after the digit mux.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=1, SCAN_DIV=2, DIGITS=3, ACTIVE_LOW=1.
1. Reset: rst_n low for 3 clocks -> count_bcd=000, seg=FF, an=111. Release with en=1, up=1 -> count_bcd=001 on the cycle after the 8th clock.
2. Carry: load 099, en=1, up=1, one tick -> count_bcd=100, wrap=0.
3. Up wrap: load 999, one up tick -> count_bcd=000, wrap=1 for exactly 1 cycle, then 0.
4. Down: load 000, one down tick -> 999 with wrap pulse. Load 100, one down tick -> 099, wrap=0. Load 0F5 -> count_bcd=095 (clamp).
5. Blanking/scan:
   - count 007 -> an stays 110 (digit 0 only).
   - count 042 -> an alternates 110/101 every 2 clocks; seg=99 when digit 1 is shown (the 4, 0x66 inverted).
   - clear while the index is 1 -> index returns to 0, an=110.
6. Priority/reset: clear, load=555 and tick in the same cycle -> count_bcd=000. rst_n low mid-scan -> seg=FF, an=111 on the next edge.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD digit type, 7-segment codes and per-digit step helper
package bcd_disp_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_step_t;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  function automatic bcd_step_t bcd_step(input bcd_digit_t d, input logic up);
    return up ? ((d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1})
              : ((d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1});
  endfunction
endpackage

// File: rtl/bcd_counter_display_decoder.sv
// bcd_seg_decoder: registered BCD to 7-segment decode with dp and output polarity
module bcd_seg_decoder
  import bcd_disp_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  bcd_digit_t digit,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [7:0] code;
  logic [7:0] lit;
  always_comb begin
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    lit = {dp, code[6:0]};
  end
  always_ff @(posedge clk)
    seg <= !rst_n ? {8{ACTIVE_LOW}} : ACTIVE_LOW ? ~lit : lit;
endmodule

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: up/down BCD counter with multiplexed 7-segment scan; BCD_DISP_DP_EN adds dp_mask
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int TICK_HZ    = 1,
  parameter int SCAN_DIV   = 10000,
  parameter int DIGITS     = 3,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_DISP_DP_EN
  input  logic [DIGITS-1:0]     dp_mask,
`endif
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int PRESC_TERM = CLK_HZ / TICK_HZ - 1;
  localparam int PW = $clog2(PRESC_TERM + 1);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(DIGITS + 1);
  logic [PW-1:0]       presc;
  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       idx, eidx;
  logic [NW-1:0]       n;
  logic [4*DIGITS-1:0] stepped, clamped;
  logic [DIGITS-1:0]   dp_bits, sel;
  logic                carry, tick, scan_term, idx_over, idx_last, dp;
  bcd_step_t           st;
  bcd_digit_t          digit;
`ifdef BCD_DISP_DP_EN
  assign dp_bits = dp_mask;
`else
  assign dp_bits = '0;
`endif
  assign tick = presc == PW'(PRESC_TERM);
  assign scan_term = scan_cnt == SW'(SCAN_DIV - 1);
  // ripple carry/borrow through every digit within one cycle
  always_comb begin
    carry = 1'b1;
    stepped = count_bcd;
    clamped = load_val;
    st = '0;
    for (int i = 0; i < DIGITS; i++) begin
      st = bcd_step(count_bcd[4*i +: 4], up);
      stepped[4*i +: 4] = carry ? st.digit : count_bcd[4*i +: 4];
      carry = carry & st.carry;
      clamped[4*i +: 4] = load_val[4*i +: 4] > 4'd9 ? 4'd9 : load_val[4*i +: 4];
    end
  end
  // active positions: highest non-zero (or dp-marked) digit + 1, at least one
  always_comb begin
    n = NW'(1);
    for (int i = 0; i < DIGITS; i++)
      if (count_bcd[4*i +: 4] != 4'd0 || dp_bits[i]) n = NW'(i + 1);
  end
  assign idx_over = 32'(idx) >= 32'(n);
  assign idx_last = 32'(idx) + 1 >= 32'(n);
  assign eidx = idx_over ? '0 : idx;
  assign digit = count_bcd[4*32'(eidx) +: 4];
  assign dp = dp_bits[eidx];
  assign sel = DIGITS'(1) << eidx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_bcd <= '0;
      wrap <= 1'b0;
      presc <= '0;
      scan_cnt <= '0;
      idx <= '0;
      an <= {DIGITS{ACTIVE_LOW}};
    end else begin
      count_bcd <= clear ? '0 : load ? clamped : (tick && en) ? stepped : count_bcd;
      wrap <= !clear && !load && tick && en && carry;
      presc <= (clear || load || tick) ? '0 : presc + 1'b1;
      scan_cnt <= scan_term ? '0 : scan_cnt + 1'b1;
      idx <= (idx_over || (scan_term && idx_last)) ? '0 : scan_term ? idx + 1'b1 : idx;
      an <= ACTIVE_LOW ? ~sel : sel;
    end
  end
  bcd_seg_decoder #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .digit(digit),
    .dp   (dp),
    .seg  (seg)
  );
endmodule
